// File: rtl/axi_log_pkg.sv
// ============================================================================
// Package     : axi_log_pkg
// Description : Shared constants and types for draining an AXI BRAM logger.
//               Defines the 96-bit log entry layout, the BRAM word geometry
//               and the drain sequencer state encoding.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi_log_pkg;

  // Entry geometry: one log entry spans three 32-bit BRAM words.
  localparam int LOG_ENTRY_BITW  = 96;
  localparam int ENTRY_WORDS     = 3;
  localparam int BRAM_WORD_BITW  = 32;
  localparam int BRAM_WORD_BYTEW = 4;

  // Field offsets inside an assembled entry.
  localparam int TS_LOW   = 0;
  localparam int ADDR_LOW = 32;
  localparam int LEN_LOW  = 64;
  localparam int ID_LOW   = 72;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    READ     = 3'd1,
    OUT      = 3'd2,
    CLEAR    = 3'd3,
    WAIT_CLR = 3'd4
  } drain_state_e;

endpackage

`default_nettype wire

// File: rtl/log_entry_assembler.sv
// ============================================================================
// Module      : log_entry_assembler
// Description : Collects the three 32-bit BRAM words of one log entry into a
//               96-bit register and flags an all-zero entry.
// Ports       : Clk_CI        - clock
//               Rst_RBI       - synchronous active-low reset
//               CapEn_SI      - capture RdData_DI this cycle
//               WordIdx_DI    - which word (0..2) is being captured
//               RdData_DI     - BRAM read data
//               Entry_DO      - assembled entry
//               EntryZero_SO  - entry including this cycle's capture is zero
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module log_entry_assembler
  import axi_log_pkg::*;
(
  input  logic                      Clk_CI,
  input  logic                      Rst_RBI,
  input  logic                      CapEn_SI,
  input  logic [1:0]                WordIdx_DI,
  input  logic [BRAM_WORD_BITW-1:0] RdData_DI,
  output logic [LOG_ENTRY_BITW-1:0] Entry_DO,
  output logic                      EntryZero_SO
);

  logic [LOG_ENTRY_BITW-1:0] entry_d, entry_q;

  always_comb begin
    entry_d = entry_q;
    if (CapEn_SI) begin
      case (WordIdx_DI)
        2'd0:    entry_d[TS_LOW +: 32]   = RdData_DI;
        2'd1:    entry_d[ADDR_LOW +: 32] = RdData_DI;
        default: begin
          entry_d[LEN_LOW +: 8]  = RdData_DI[7:0];
          entry_d[ID_LOW +: 24]  = RdData_DI[31:8];
        end
      endcase
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  // Looks at the next-state value so the verdict is available in the same
  // cycle that the last word lands, without an extra evaluation cycle.
  assign EntryZero_SO = (entry_d == '0);
  assign Entry_DO     = entry_q;

endmodule

`default_nettype wire

// File: rtl/axi_log_drain_ctrl.sv
// ============================================================================
// Module      : axi_log_drain_ctrl
// Description : Drains an AXI BRAM logger over its 32-bit BRAM port. Reads
//               entries in order, streams non-empty entries on a valid/ready
//               interface, stops at the first empty entry or the last entry,
//               then pulses the logger clear and waits for the sweep.
// Ports       : Clk_CI/Rst_RBI           - clock, sync active-low reset
//               Start_SI                 - start a drain (pulse)
//               Busy_SO/Done_SO          - status, done pulse
//               NumDrained_DO            - entries emitted by last drain
//               BramEn_SO/BramAddr_DO/BramWrEn_SO/BramRd_DI - BRAM port
//               LogFull_SI/LogClear_SO   - logger full flag / clear strobe
//               EntryValid_SO/EntryReady_SI/EntryData_DO - entry stream
// Config      : AXI_LOG_DRAIN_AUTO_EN - when defined, a rising edge of
//               LogFull_SI in IDLE starts a drain like Start_SI.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_log_drain_ctrl
  import axi_log_pkg::*;
#(
  parameter int NUM_LOG_ENTRIES = 16384,
  parameter int CLR_CYCLES      = 1024 * ((NUM_LOG_ENTRIES + 1023) / 1024)
) (
  input  logic                               Clk_CI,
  input  logic                               Rst_RBI,
  input  logic                               Start_SI,
  output logic                               Busy_SO,
  output logic                               Done_SO,
  output logic [$clog2(NUM_LOG_ENTRIES):0]   NumDrained_DO,
  output logic                               BramEn_SO,
  output logic [31:0]                        BramAddr_DO,
  output logic [3:0]                         BramWrEn_SO,
  input  logic [31:0]                        BramRd_DI,
  input  logic                               LogFull_SI,
  output logic                               LogClear_SO,
  output logic                               EntryValid_SO,
  input  logic                               EntryReady_SI,
  output logic [LOG_ENTRY_BITW-1:0]          EntryData_DO
);

  localparam int CNT_W   = $clog2(NUM_LOG_ENTRIES);
  localparam int DRAIN_W = $clog2(NUM_LOG_ENTRIES) + 1;
  localparam int WAIT_W  = $clog2(CLR_CYCLES + 2);

  drain_state_e        state_d, state_q;
  logic [CNT_W-1:0]    entry_cnt_d, entry_cnt_q;
  logic [1:0]          word_cnt_d, word_cnt_q;
  logic [DRAIN_W-1:0]  num_drained_d, num_drained_q;
  logic [WAIT_W-1:0]   wait_cnt_d, wait_cnt_q;

  logic                start_req;
  logic                cap_en;
  logic                entry_zero;
  logic [31:0]         word_idx;

`ifdef AXI_LOG_DRAIN_AUTO_EN
  logic full_d, full_q;

  assign full_d    = LogFull_SI;
  assign start_req = Start_SI | (LogFull_SI & ~full_q);

  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      full_q <= 1'b0;
    end else begin
      full_q <= full_d;
    end
  end
`else
  logic unused_log_full;

  assign unused_log_full = LogFull_SI;
  assign start_req       = Start_SI;
`endif

  // Word counter runs 0..3 in READ: issues on 0..2, captures on 1..3, so the
  // captured word is always the one issued in the previous cycle.
  log_entry_assembler u_assembler (
    .Clk_CI       (Clk_CI),
    .Rst_RBI      (Rst_RBI),
    .CapEn_SI     (cap_en),
    .WordIdx_DI   (word_cnt_q - 2'd1),
    .RdData_DI    (BramRd_DI),
    .Entry_DO     (EntryData_DO),
    .EntryZero_SO (entry_zero)
  );

  always_comb begin
    state_d       = state_q;
    entry_cnt_d   = entry_cnt_q;
    word_cnt_d    = word_cnt_q;
    num_drained_d = num_drained_q;
    wait_cnt_d    = wait_cnt_q;
    BramEn_SO     = 1'b0;
    cap_en        = 1'b0;
    LogClear_SO   = 1'b0;
    EntryValid_SO = 1'b0;
    Done_SO       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_req) begin
          state_d       = READ;
          entry_cnt_d   = '0;
          word_cnt_d    = '0;
          num_drained_d = '0;
        end
      end

      READ: begin
        BramEn_SO = (word_cnt_q != 2'd3);
        cap_en    = (word_cnt_q != 2'd0);
        if (word_cnt_q == 2'd3) begin
          word_cnt_d = '0;
          state_d    = entry_zero ? CLEAR : OUT;
        end else begin
          word_cnt_d = word_cnt_q + 2'd1;
        end
      end

      OUT: begin
        EntryValid_SO = 1'b1;
        if (EntryReady_SI) begin
          num_drained_d = num_drained_q + DRAIN_W'(1);
          if (entry_cnt_q == CNT_W'(NUM_LOG_ENTRIES - 1)) begin
            state_d = CLEAR;
          end else begin
            entry_cnt_d = entry_cnt_q + CNT_W'(1);
            state_d     = READ;
          end
        end
      end

      CLEAR: begin
        LogClear_SO = 1'b1;
        wait_cnt_d  = WAIT_W'(CLR_CYCLES + 1);
        state_d     = WAIT_CLR;
      end

      WAIT_CLR: begin
        if (wait_cnt_q == '0) begin
          Done_SO = 1'b1;
          state_d = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q - WAIT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      state_q       <= IDLE;
      entry_cnt_q   <= '0;
      word_cnt_q    <= '0;
      num_drained_q <= '0;
      wait_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      entry_cnt_q   <= entry_cnt_d;
      word_cnt_q    <= word_cnt_d;
      num_drained_q <= num_drained_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  assign word_idx      = 32'(entry_cnt_q) * 32'(ENTRY_WORDS) + 32'(word_cnt_q);
  assign BramAddr_DO   = BramEn_SO ? (word_idx * 32'(BRAM_WORD_BYTEW)) : 32'd0;
  assign BramWrEn_SO   = 4'b0000;
  assign Busy_SO       = (state_q != IDLE);
  assign NumDrained_DO = num_drained_q;

endmodule

`default_nettype wire

// File: tb/tb_axi_log_drain_ctrl.sv
// ============================================================================
// Module      : tb_axi_log_drain_ctrl
// Description : Self-checking bench for axi_log_drain_ctrl with a BRAM-backed
//               logger image, random ready back-pressure and a queue-based
//               model of which entries a drain must emit.
// Ports       : none
// Config      : AXI_LOG_DRAIN_AUTO_EN selects the auto-start scenario.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_log_drain_ctrl;

  localparam int N      = 1024;
  localparam int CLR    = 1024;
  localparam int DW     = $clog2(N) + 1;
  localparam int BUDGET = 30000;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          start    = 1'b0;
  logic          log_full = 1'b0;
  logic          er       = 1'b1;
  logic [31:0]   bram_rd  = '0;
  logic          busy, done, bram_en, log_clear, ev;
  logic [DW-1:0] num_drained;
  logic [31:0]   bram_addr;
  logic [3:0]    bram_we;
  logic [95:0]   edata;

  logic [31:0]   mem [0:3*N-1];

  int            checks   = 0;
  int            failures = 0;

  logic [95:0]   got_q[$];
  logic [95:0]   exp_q[$];
  logic [31:0]   addr_q[$];
  logic [31:0]   exp_addr_q[$];
  int            clear_q[$];
  int            done_cycle;
  int            stall_bad;

  axi_log_drain_ctrl #(
    .NUM_LOG_ENTRIES (N),
    .CLR_CYCLES      (CLR)
  ) dut (
    .Clk_CI        (clk),
    .Rst_RBI       (rst_n),
    .Start_SI      (start),
    .Busy_SO       (busy),
    .Done_SO       (done),
    .NumDrained_DO (num_drained),
    .BramEn_SO     (bram_en),
    .BramAddr_DO   (bram_addr),
    .BramWrEn_SO   (bram_we),
    .BramRd_DI     (bram_rd),
    .LogFull_SI    (log_full),
    .LogClear_SO   (log_clear),
    .EntryValid_SO (ev),
    .EntryReady_SI (er),
    .EntryData_DO  (edata)
  );

  always #5 clk = ~clk;

  // Logger BRAM image with one cycle read latency.
  always @(posedge clk) begin
    if (bram_en) bram_rd <= mem[int'(bram_addr >> 2) % (3 * N)];
  end

  task automatic clear_mem();
    for (int i = 0; i < 3 * N; i++) mem[i] = '0;
  endtask

  task automatic fill_random(input int count);
    for (int i = 0; i < count; i++) begin
      mem[3*i]   = $urandom | 32'h1;
      mem[3*i+1] = $urandom;
      mem[3*i+2] = $urandom;
    end
  endtask

  // Expected drain: walk entries in order, every visited entry costs three
  // word reads, stop after an all-zero entry or after the last entry.
  task automatic build_model();
    logic [95:0] e;
    exp_q.delete();
    exp_addr_q.delete();
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < 3; k++) exp_addr_q.push_back(32'((3 * i + k) * 4));
      e = {mem[3*i+2], mem[3*i+1], mem[3*i]};
      if (e == '0) break;
      exp_q.push_back(e);
    end
  endtask

  task automatic run_drain(input int ready_pct, input int stall_cycles, input int start_mid_cyc,
                           input bit use_start, input bit start_at_done);
    int          cyc;
    int          stall_left;
    bit          seen_done;
    bit          was_stalled;
    logic [95:0] held;
    cyc         = 0;
    stall_left  = stall_cycles;
    seen_done   = 1'b0;
    was_stalled = 1'b0;
    held        = '0;
    got_q.delete();
    addr_q.delete();
    clear_q.delete();
    done_cycle = -1;
    stall_bad  = 0;
    if (use_start) start = 1'b1;
    else log_full = 1'b1;
    while (!seen_done && cyc < BUDGET) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc++;
      if (cyc == start_mid_cyc) start = 1'b1;
      if (bram_en) addr_q.push_back(bram_addr);
      if (log_clear) clear_q.push_back(cyc);
      if (was_stalled && (!ev || edata !== held || bram_en)) stall_bad++;
      if (done) begin
        seen_done  = 1'b1;
        done_cycle = cyc;
        if (start_at_done) start = 1'b1;
      end
      if (ev && stall_left > 0) begin
        er = 1'b0;
        stall_left--;
      end else begin
        er = ($urandom_range(99) < ready_pct);
      end
      was_stalled = ev && !er;
      held        = edata;
      if (ev && er) got_q.push_back(edata);
    end
    if (!seen_done) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: Done_SO not seen, got none within %0d cycles", BUDGET);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    er    = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, bram_en, log_clear, ev} !== 5'b0) begin
      failures++;
      $display("FAIL reset_status: got %b expected 00000", {busy, done, bram_en, log_clear, ev});
    end
    checks++;
    if (num_drained !== '0) begin
      failures++;
      $display("FAIL reset_num_drained: got %0d expected 0", num_drained);
    end
    checks++;
    if ({bram_addr, bram_we} !== 36'h0) begin
      failures++;
      $display("FAIL reset_bram: got addr %0h we %0h expected 0", bram_addr, bram_we);
    end
    checks++;
    if (edata !== 96'h0) begin
      failures++;
      $display("FAIL reset_entry_data: got %0h expected 0", edata);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_two_entries();
    logic [95:0] e0;
    logic [95:0] e1;
    e0 = {24'd7, 8'd3, 32'h1000, 32'd5};
    e1 = {24'd1, 8'd0, 32'h2000, 32'd9};
    clear_mem();
    mem[0] = 32'd5; mem[1] = 32'h1000; mem[2] = 32'h703;
    mem[3] = 32'd9; mem[4] = 32'h2000; mem[5] = 32'h100;
    // A second Start_SI mid-drain must not restart anything.
    run_drain(100, 0, 7, 1'b1, 1'b0);
    checks++;
    if (got_q.size() !== 2) begin
      failures++;
      $display("FAIL two_count: got %0d entries expected 2", got_q.size());
    end
    checks++;
    if (got_q[0] !== e0) begin
      failures++;
      $display("FAIL two_entry0: got %0h expected %0h", got_q[0], e0);
    end
    checks++;
    if (got_q[1] !== e1) begin
      failures++;
      $display("FAIL two_entry1: got %0h expected %0h", got_q[1], e1);
    end
    checks++;
    if (addr_q.size() !== 9) begin
      failures++;
      $display("FAIL two_addr_count: got %0d expected 9", addr_q.size());
    end
    for (int i = 0; i < addr_q.size(); i++) begin
      checks++;
      if (addr_q[i] !== 32'(i * 4)) begin
        failures++;
        $display("FAIL two_addr[%0d]: got %0h expected %0h", i, addr_q[i], i * 4);
      end
    end
    checks++;
    if (clear_q.size() !== 1) begin
      failures++;
      $display("FAIL two_clear_pulses: got %0d expected 1", clear_q.size());
    end
    checks++;
    if (done_cycle - clear_q[0] !== CLR + 2) begin
      failures++;
      $display("FAIL two_done_delay: got %0d expected %0d", done_cycle - clear_q[0], CLR + 2);
    end
    checks++;
    if (num_drained !== DW'(2)) begin
      failures++;
      $display("FAIL two_num_drained: got %0d expected 2", num_drained);
    end
  endtask

  task automatic test_empty();
    clear_mem();
    run_drain(100, 0, -1, 1'b1, 1'b0);
    checks++;
    if (got_q.size() !== 0) begin
      failures++;
      $display("FAIL empty_count: got %0d entries expected 0", got_q.size());
    end
    checks++;
    if (addr_q.size() !== 3) begin
      failures++;
      $display("FAIL empty_reads: got %0d reads expected 3", addr_q.size());
    end
    checks++;
    if (clear_q.size() !== 1 || done_cycle - clear_q[0] !== CLR + 2) begin
      failures++;
      $display("FAIL empty_clear: got %0d pulses delay %0d expected 1 and %0d",
               clear_q.size(), done_cycle - clear_q[0], CLR + 2);
    end
    checks++;
    if (num_drained !== '0) begin
      failures++;
      $display("FAIL empty_num_drained: got %0d expected 0", num_drained);
    end
  endtask

  task automatic test_stall();
    int cnt;
    int bad;
    cnt = int'($urandom_range(8, 3));
    clear_mem();
    fill_random(cnt);
    build_model();
    run_drain(60, 20, -1, 1'b1, 1'b0);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL stall_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL stall_data: got %0d wrong entries expected 0 (first %0h vs %0h)",
               bad, got_q[0], exp_q[0]);
    end
    checks++;
    if (stall_bad !== 0) begin
      failures++;
      $display("FAIL stall_hold: got %0d unstable/read cycles expected 0", stall_bad);
    end
    bad = 0;
    for (int i = 0; i < exp_addr_q.size(); i++) if (addr_q[i] !== exp_addr_q[i]) bad++;
    checks++;
    if (bad !== 0 || addr_q.size() !== exp_addr_q.size()) begin
      failures++;
      $display("FAIL stall_addr: got %0d reads %0d wrong expected %0d reads",
               addr_q.size(), bad, exp_addr_q.size());
    end
    checks++;
    if (num_drained !== DW'(exp_q.size())) begin
      failures++;
      $display("FAIL stall_num_drained: got %0d expected %0d", num_drained, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_read();
    int seen;
    clear_mem();
    fill_random(2);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++;
    if ({busy, done, bram_en, log_clear, ev} !== 5'b0 || bram_addr !== 32'h0) begin
      failures++;
      $display("FAIL midreset_outputs: got status %b addr %0h expected 0",
               {busy, done, bram_en, log_clear, ev}, bram_addr);
    end
    checks++;
    if (num_drained !== '0 || edata !== 96'h0) begin
      failures++;
      $display("FAIL midreset_data: got num %0d data %0h expected 0", num_drained, edata);
    end
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (busy || log_clear || done) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL midreset_quiet: got %0d active cycles expected 0", seen);
    end
  endtask

  task automatic test_log_full();
    int seen;
`ifdef AXI_LOG_DRAIN_AUTO_EN
    clear_mem();
    fill_random(2);
    build_model();
    run_drain(100, 0, -1, 1'b0, 1'b0);
    checks++;
    if (got_q.size() !== exp_q.size() || num_drained !== DW'(exp_q.size())) begin
      failures++;
      $display("FAIL auto_drain: got %0d entries num %0d expected %0d",
               got_q.size(), num_drained, exp_q.size());
    end
`else
    log_full = 1'b1;
`endif
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (busy) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL full_held_no_drain: got %0d busy cycles expected 0", seen);
    end
    log_full = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_full_log();
    int bad;
    int seen;
    clear_mem();
    fill_random(N);
    build_model();
    // Start_SI asserted during the Done_SO cycle must be ignored.
    run_drain(80, 0, -1, 1'b1, 1'b1);
    checks++;
    if (got_q.size() !== N) begin
      failures++;
      $display("FAIL full_count: got %0d expected %0d", got_q.size(), N);
    end
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL full_data: got %0d wrong entries expected 0", bad);
    end
    checks++;
    if (addr_q.size() !== 3 * N || addr_q[addr_q.size() - 1] !== 32'h2FFC) begin
      failures++;
      $display("FAIL full_last_addr: got %0d reads last %0h expected %0d reads last 2ffc",
               addr_q.size(), addr_q[addr_q.size() - 1], 3 * N);
    end
    checks++;
    if (num_drained !== DW'(N)) begin
      failures++;
      $display("FAIL full_num_drained: got %0d expected %0d", num_drained, N);
    end
    checks++;
    if (clear_q.size() !== 1 || done_cycle - clear_q[0] !== CLR + 2) begin
      failures++;
      $display("FAIL full_clear: got %0d pulses delay %0d expected 1 and %0d",
               clear_q.size(), done_cycle - clear_q[0], CLR + 2);
    end
    checks++;
    if (stall_bad !== 0) begin
      failures++;
      $display("FAIL full_hold: got %0d unstable cycles expected 0", stall_bad);
    end
    seen = 0;
    repeat (10) begin
      if (busy) seen++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL start_at_done: got %0d busy cycles expected 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_two_entries();
    test_empty();
    test_stall();
    test_reset_mid_read();
    test_log_full();
    test_full_log();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
